// File: rtl/button_event_arbiter_if.sv
// Event output handshake of button_event_arbiter: one event per valid/ready transfer.
interface button_event_arbiter_if #(
  parameter int unsigned ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_repeat;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_repeat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_repeat,
    output evt_ready
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into press / auto-repeat events, buffered one per button
// and granted round-robin into a single registered valid/ready output.
module button_event_arbiter #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250,
  parameter int unsigned ID_W          = $clog2(N_BTN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_BTN-1:0]      btn_in,
  input  logic                  enable,
  button_event_arbiter_if.master evt,
  output logic [N_BTN-1:0]      pending,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int unsigned CntMax   = HOLD_CYCLES + REPEAT_CYCLES;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldVal = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] WrapVal = CntW'(CntMax);
  localparam bit RepeatEn = (HOLD_CYCLES != 0);

  logic [N_BTN-1:0]           btn_prev_q;
  logic [N_BTN-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0]           armed_q, armed_d;
  logic [N_BTN-1:0]           pend_q, pend_d;
  logic [N_BTN-1:0]           pend_rep_q, pend_rep_d;
  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic                       evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]            evt_id_q, evt_id_d;
  logic                       evt_repeat_q, evt_repeat_d;
  logic                       ovf_q, ovf_d;

  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rep_req;
  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] grant_vec;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic             load;
  logic             ovf_set;
  logic [ID_W:0]    scan_sum;
  logic [ID_W-1:0]  scan_idx;

  // Hold counters only run for a hold that began with an accepted press (armed), so a
  // button held through reset or through enable=0 never auto-repeats.
  always_comb begin
    press   = btn_in & ~btn_prev_q & {N_BTN{enable}};
    rep_req = '0;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (!enable || !btn_in[i]) begin
        cnt_d[i]   = '0;
        armed_d[i] = 1'b0;
      end else if (press[i]) begin
        cnt_d[i]   = '0;
        armed_d[i] = RepeatEn;
      end else if (armed_q[i]) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
        if (cnt_d[i] == WrapVal) begin
          rep_req[i] = 1'b1;
          cnt_d[i]   = HoldVal;
        end else if (cnt_d[i] == HoldVal) begin
          rep_req[i] = 1'b1;
        end
      end
    end
    req = press | rep_req;
  end

  // Round-robin scan of the registered pending bits, starting at the pointer.
  always_comb begin
    load      = !evt_valid_q || evt.evt_ready;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      scan_sum = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (scan_sum >= (ID_W + 1)'(N_BTN)) begin
        scan_sum = scan_sum - (ID_W + 1)'(N_BTN);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!grant_any && pend_q[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (load && grant_any) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    pend_d     = pend_q;
    pend_rep_d = pend_rep_q;
    ovf_set    = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (req[i]) begin
        if (pend_q[i] && !grant_vec[i]) begin
          ovf_set = 1'b1;
        end
        pend_d[i]     = 1'b1;
        pend_rep_d[i] = rep_req[i];
      end else if (grant_vec[i]) begin
        pend_d[i] = 1'b0;
      end
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    evt_repeat_d = evt_repeat_q;
    ptr_d        = ptr_q;
    if (load) begin
      evt_valid_d = grant_any;
      if (grant_any) begin
        evt_id_d     = grant_idx;
        evt_repeat_d = pend_rep_q[grant_idx];
        if (grant_idx == ID_W'(N_BTN - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_idx + ID_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev_q   <= '1;
      cnt_q        <= '0;
      armed_q      <= '0;
      pend_q       <= '0;
      pend_rep_q   <= '0;
      ptr_q        <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_repeat_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      btn_prev_q   <= btn_in;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      pend_q       <= pend_d;
      pend_rep_q   <= pend_rep_d;
      ptr_q        <= ptr_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_repeat_q <= evt_repeat_d;
      ovf_q        <= ovf_d;
    end
  end

  assign evt.evt_valid  = evt_valid_q;
  assign evt.evt_id     = evt_id_q;
  assign evt.evt_repeat = evt_repeat_q;
  assign pending        = pend_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural event model.
module tb_button_event_arbiter;

  localparam int N = 4;
  localparam int H = 8;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn_in = '0;
  logic       enable = 1'b1;
  logic [3:0] pending;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  button_event_arbiter_if #(.ID_W(2)) evt ();

  button_event_arbiter #(
    .N_BTN        (N),
    .HOLD_CYCLES  (H),
    .REPEAT_CYCLES(R),
    .ID_W         (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_in  (btn_in),
    .enable  (enable),
    .evt     (evt),
    .pending (pending),
    .overflow(overflow),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: held[i] = samples since the accepted press (-1 when not armed).
  logic [3:0] m_prev;
  int         m_held[4];
  logic [3:0] m_pend;
  logic [3:0] m_rep;
  int         m_ptr;
  logic       m_valid;
  int         m_id;
  logic       m_repo;
  logic       m_ovf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_prev  <= '1;
      for (int i = 0; i < N; i++) m_held[i] <= -1;
      m_pend  <= '0;
      m_rep   <= '0;
      m_ptr   <= 0;
      m_valid <= 1'b0;
      m_id    <= 0;
      m_repo  <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin : step
      logic       prs, rep, set_ovf, free;
      int         g, nh, idx;
      logic [3:0] np, nr;
      g       = -1;
      set_ovf = 1'b0;
      np      = m_pend;
      nr      = m_rep;
      free    = !m_valid || evt.evt_ready;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && m_pend[idx]) g = idx;
        end
      end
      for (int i = 0; i < N; i++) begin
        prs = btn_in[i] && !m_prev[i] && enable;
        rep = 1'b0;
        if (prs) begin
          nh = 0;
        end else if (btn_in[i] && enable && m_held[i] >= 0) begin
          nh  = m_held[i] + 1;
          rep = (nh == H) || (nh > H && (nh - H) % R == 0);
        end else begin
          nh = -1;
        end
        m_held[i] <= nh;
        if (g == i) np[i] = 1'b0;
        if (prs || rep) begin
          if (m_pend[i] && g != i) set_ovf = 1'b1;
          np[i] = 1'b1;
          nr[i] = rep;
        end
      end
      m_pend <= np;
      m_rep  <= nr;
      if (set_ovf) m_ovf <= 1'b1;
      else if (ovf_clr) m_ovf <= 1'b0;
      if (free) begin
        m_valid <= (g >= 0);
        if (g >= 0) begin
          m_id   <= g;
          m_repo <= m_rep[g];
          m_ptr  <= (g + 1) % N;
        end
      end
      m_prev <= btn_in;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      check("evt_valid", 32'(evt.evt_valid), 32'(m_valid));
      check("pending", 32'(pending), 32'(m_pend));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_valid) begin
        check("evt_id", 32'(evt.evt_id), 32'(m_id));
        check("evt_repeat", 32'(evt.evt_repeat), 32'(m_repo));
      end
    end
  end

  // Log of accepted events with the cycle of acceptance.
  int log_id[$];
  int log_rep[$];
  int log_cyc[$];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && evt.evt_valid && evt.evt_ready) begin
      log_id.push_back(int'(evt.evt_id));
      log_rep.push_back(int'(evt.evt_repeat));
      log_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    log_id.delete();
    log_rep.delete();
    log_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic check_ev(input string name, input int k, input int id, input int rep);
    if (k < log_id.size()) begin
      check({name, "_id"}, 32'(log_id[k]), 32'(id));
      check({name, "_rep"}, 32'(log_rep[k]), 32'(rep));
    end else begin
      check({name, "_present"}, 32'(log_id.size()), 32'(k + 1));
    end
  endtask

  task automatic check_gap(input string name, input int a, input int b, input int gap);
    if (b < log_cyc.size()) check(name, 32'(log_cyc[b] - log_cyc[a]), 32'(gap));
    else check({name, "_present"}, 32'(log_cyc.size()), 32'(b + 1));
  endtask

  initial begin
    evt.evt_ready = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check("rst_valid", 32'(evt.evt_valid), 32'd0);
    check("rst_id", 32'(evt.evt_id), 32'd0);
    check("rst_repeat", 32'(evt.evt_repeat), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single press: pending after one edge, event after two.
    clear_log();
    btn_in = 4'b0001;
    tick(1);
    check("press_pend", 32'(pending), 32'b0001);
    check("press_not_yet", 32'(evt.evt_valid), 32'd0);
    tick(1);
    check("press_valid", 32'(evt.evt_valid), 32'd1);
    check("press_id", 32'(evt.evt_id), 32'd0);
    tick(3);
    btn_in = '0;
    tick(5);
    check("single_count", 32'(log_id.size()), 32'd1);
    check_ev("single", 0, 0, 0);
    check("single_ovf", 32'(overflow), 32'd0);

    // Fairness from pointer 0, then 0 and 3 together.
    do_reset();
    clear_log();
    btn_in = 4'b1111;
    tick(2);
    btn_in = '0;
    tick(8);
    check("fair_count", 32'(log_id.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_ev("fair", k, k, 0);
      check_gap("fair_gap", 0, k, k);
    end
    btn_in = 4'b1001;
    tick(1);
    btn_in = '0;
    tick(6);
    check_ev("pair_first", 4, 0, 0);
    check_ev("pair_second", 5, 3, 0);

    // Backpressure and overflow.
    clear_log();
    evt.evt_ready = 1'b0;
    btn_in = 4'b0010;
    tick(1);
    btn_in = '0;
    tick(3);
    check("stall_valid", 32'(evt.evt_valid), 32'd1);
    check("stall_id", 32'(evt.evt_id), 32'd1);
    btn_in = 4'b0010;
    tick(1);
    btn_in = '0;
    tick(1);
    check("repress_pend", 32'(pending), 32'b0010);
    check("repress_no_ovf", 32'(overflow), 32'd0);
    btn_in = 4'b0010;
    tick(1);
    btn_in = '0;
    tick(1);
    check("ovf_pend", 32'(pending), 32'b0010);
    check("ovf_set", 32'(overflow), 32'd1);
    check("stall_id_held", 32'(evt.evt_id), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    evt.evt_ready = 1'b1;
    tick(4);
    check("drain_count", 32'(log_id.size()), 32'd2);
    check_ev("drain", 1, 1, 0);

    // Auto-repeat: requests at held samples 8, 11, 14, 17.
    clear_log();
    btn_in = 4'b0100;
    tick(20);
    btn_in = '0;
    tick(12);
    check("rep_count", 32'(log_id.size()), 32'd5);
    check_ev("rep_press", 0, 2, 0);
    for (int k = 1; k < 5; k++) check_ev("rep_evt", k, 2, 1);
    check_gap("rep_first_gap", 0, 1, 8);
    check_gap("rep_gap2", 1, 2, 3);
    check_gap("rep_gap3", 2, 3, 3);
    check_gap("rep_gap4", 3, 4, 3);

    // Button held through reset, then enable=0.
    btn_in = 4'b0001;
    do_reset();
    clear_log();
    tick(15);
    check("held_rst_count", 32'(log_id.size()), 32'd0);
    btn_in = '0;
    tick(1);
    btn_in = 4'b0001;
    tick(1);
    btn_in = '0;
    tick(4);
    check("held_rst_repress", 32'(log_id.size()), 32'd1);
    enable = 1'b0;
    btn_in = 4'b1000;
    tick(1);
    check("dis_pend", 32'(pending), 32'd0);
    btn_in = '0;
    tick(4);
    check("dis_count", 32'(log_id.size()), 32'd1);
    enable = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) btn_in[i] = ~btn_in[i];
      end
      evt.evt_ready = ($urandom_range(0, 3) != 0);
      enable        = ($urandom_range(0, 19) != 0);
      ovf_clr       = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    btn_in = '0;
    enable = 1'b1;
    ovf_clr = 1'b0;
    evt.evt_ready = 1'b1;
    tick(10);

    // Asynchronous reset between clock edges with state loaded.
    do_reset();
    evt.evt_ready = 1'b0;
    btn_in = 4'b0001;
    tick(1);
    btn_in = '0;
    tick(3);
    btn_in = 4'b0110;
    tick(1);
    btn_in = '0;
    tick(1);
    btn_in = 4'b0010;
    tick(1);
    btn_in = '0;
    tick(1);
    check("pre_rst_valid", 32'(evt.evt_valid), 32'd1);
    check("pre_rst_pend", 32'(pending), 32'b0110);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", 32'(evt.evt_valid), 32'd0);
    check("async_pend", 32'(pending), 32'd0);
    check("async_ovf", 32'(overflow), 32'd0);
    tick(2);
    reset_n = 1'b1;
    evt.evt_ready = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects the debounced push-button levels from the per-button debounce instances and converts them into a single stream of discrete button events for the board control logic. Each button gets rising-edge detection and optional hold-to-repeat. Requests are buffered in one pending bit per button and granted round-robin into a one-entry output register with a valid/ready handshake.

## Interface
- N_BTN, 4: number of debounced button inputs, 2..16.
- HOLD_CYCLES, 1000: samples held high after the press sample before the first repeat; 0 disables auto-repeat, otherwise ≥2.
- REPEAT_CYCLES, 250: samples between later repeats while held, ≥1.
- ID_W, $clog2(N_BTN): width of evt_id.

- clk  in  1  single clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- btn_in  in  N_BTN  debounced button levels, synchronous to clk, 1 = pressed.
- enable  in  1  1 = accept new requests; 0 = discard new presses and repeats.
- evt_valid  out  1  output event present.
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready at posedge.
- evt_id  out  ID_W  index of the button for this event.
- evt_repeat  out  1  0 = press event, 1 = auto-repeat event.
- pending  out  N_BTN  pending request bits, for debug or status.
- overflow  out  1  sticky flag: a request was dropped.
- ovf_clr  in  1  synchronous clear of overflow.

## Operation
- Reset values: evt_valid=0, evt_id=0, evt_repeat=0, pending=0, overflow=0, hold counters=0, round-robin pointer=0, btn_prev=all ones.
- Because btn_prev resets to all ones, a button held through reset produces no event until it is released and pressed again.
- Press request for button i: btn_in[i] & ~btn_prev[i] & enable. btn_prev updates every cycle, whatever the value of enable.
- Hold counter i:
  - Clears on a press sample and while btn_in[i]=0.
  - Increments on each later sample with btn_in[i]=1.
  - Generates a repeat request when the count equals HOLD_CYCLES, then at every further REPEAT_CYCLES samples.
  - Saturates or wraps internally without spurious requests.
  - Is forced to 0 while enable=0.
- Request i sets pending[i] and records its kind (press or repeat) in pend_rep[i].
- If pending[i] is already set and is not being granted in the same cycle, the new request is dropped and overflow is set.
- If the grant of i and a new request for i fall in the same cycle, the old entry goes out, the new one stays pending, and overflow is not set.
- Output register loads when !evt_valid || evt_ready. This allows one event per cycle at full throughput.
- Arbitration:
  - Round-robin over pending bits, searching from the pointer upward and wrapping modulo N_BTN.
  - On a grant of i: load evt_id=i and evt_repeat=pend_rep[i], clear pending[i], set the pointer to (i+1) mod N_BTN.
  - If nothing is pending and the register is free, evt_valid goes to 0.
- While evt_valid=1 and evt_ready=0, evt_id and evt_repeat hold stable and no grant happens.
- enable=0 does not flush pending or the output register; both keep draining normally.
- overflow: set has priority over ovf_clr in the same cycle.
- Asynchronous reset mid-operation clears all state at once, including any event that was being accepted.

## Timing
- Press latency: btn_in[i] first sampled high at posedge t → pending[i]=1 after t → evt_valid=1 after t+1 if the register is free. That is 2 cycles.
- First repeat: a press sampled at t gives the repeat request at posedge t+HOLD_CYCLES. The next ones follow at +REPEAT_CYCLES each.
- All outputs are registered. There is no combinational path from evt_ready to evt_valid.
- Simultaneous presses on k buttons give k events on consecutive cycles when evt_ready=1, in round-robin order from the pointer.

## Test plan
- Single press: reset, deassert, then btn_in=0001 for 5 cycles with evt_ready=1 → exactly one event (id 0, repeat 0) 2 cycles after the press, pending back to 0, overflow=0.
- Fairness: btn_in 0000→1111 in one cycle, evt_ready=1, pointer 0 → ids 0,1,2,3 on four consecutive cycles. Then press buttons 0 and 3 together → id 0 first, then 3.
- Backpressure and overflow: evt_ready=0, press button 1 → the event stalls with id 1 held stable. Release and re-press button 1 twice → pending[1]=1 and overflow=1. Pulse ovf_clr → overflow=0.
- Auto-repeat: HOLD_CYCLES=8, REPEAT_CYCLES=3, hold button 2 for 20 cycles → press event, then repeat events from requests at samples 8, 11, 14, 17. Release → no further events.
- Enable and reset held: hold btn_in[0]=1 across reset → no event until released and re-pressed. With enable=0, press button 3 → no event and pending stays 0.
- Async reset mid-transfer: assert reset_n=0 while evt_valid=1 and pending=0110, between clock edges → evt_valid, pending and overflow go to 0 immediately, without waiting for a clock.
